// File: rtl/stream_capture.sv
// stream_capture: sinks a 32-bit data/last/valid/ready stream and writes each
// beat as one word into a configurable memory window, optionally circular.
// A single-entry output register decouples the stream from the write port;
// capture statistics hold after the done pulse until the next accepted config.
module stream_capture #(
  parameter int AWIDTH  = 13,
  parameter int WRAP_CW = 8
) (
  input  logic                clk,
  input  logic                rstf,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [31:0]         cfg_start_addr,
  input  logic [AWIDTH:0]     cfg_length,
  input  logic                cfg_wrap,
  input  logic                abort,
  input  logic [31:0]         t_data,
  input  logic                t_last,
  input  logic                t_valid,
  output logic                t_ready,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_we,
  output logic [3:0]          m_mask,
  output logic [31:0]         m_addr,
  output logic [31:0]         m_data,
  output logic                busy,
  output logic                done,
  output logic [AWIDTH:0]     words,
  output logic [WRAP_CW-1:0]  wraps,
  output logic [1:0]          end_cause
);

  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH} state_t;

  localparam logic [AWIDTH:0]    IDX_ONE   = 1;
  localparam logic [WRAP_CW-1:0] WRAP_ONE  = 1;
  localparam logic [1:0]         CAUSE_LAST  = 2'd0;
  localparam logic [1:0]         CAUSE_FULL  = 2'd1;
  localparam logic [1:0]         CAUSE_ABORT = 2'd2;

  state_t          state;
  logic [29:0]     start_word;
  logic [AWIDTH:0] length;
  logic [AWIDTH:0] index;
  logic            wrap_mode;

  logic            beat;
  logic            index_last;
  logic [31:0]     beat_addr;
  logic            unused_addr_bits;

  // The window base is word aligned; the low byte-address bits are dropped.
  assign unused_addr_bits = &{1'b0, cfg_start_addr[1:0]};

  assign cfg_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign m_we       = 1'b1;
  assign m_mask     = 4'hF;

  // A beat may enter whenever the output register is empty or draining this cycle.
  assign t_ready    = (state == CAPTURE) && (!m_valid || m_ready);
  assign beat       = t_valid && t_ready;
  assign index_last = (index == (length - IDX_ONE));
  // Plain 32-bit add: a window placed near the top of memory wraps modulo 2^32.
  assign beat_addr  = {start_word, 2'b00} + {{(32 - AWIDTH - 3){1'b0}}, index, 2'b00};

  // Control FSM, output register and capture statistics.
  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      state      <= IDLE;
      start_word <= '0;
      length     <= '0;
      index      <= '0;
      wrap_mode  <= 1'b0;
      m_valid    <= 1'b0;
      m_addr     <= '0;
      m_data     <= '0;
      done       <= 1'b0;
      words      <= '0;
      wraps      <= '0;
      end_cause  <= CAUSE_LAST;
    end else begin
      done <= 1'b0;
      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          // A zero-length request is acknowledged but starts nothing.
          if (cfg_valid && (cfg_length != '0)) begin
            start_word <= cfg_start_addr[31:2];
            length     <= cfg_length;
            wrap_mode  <= cfg_wrap;
            index      <= '0;
            words      <= '0;
            wraps      <= '0;
            end_cause  <= CAUSE_LAST;
            state      <= CAPTURE;
          end
        end

        CAPTURE: begin
          if (beat) begin
            m_valid <= 1'b1;
            m_data  <= t_data;
            m_addr  <= beat_addr;
            if (words != '1) begin
              words <= words + IDX_ONE;
            end
            if (!index_last) begin
              index <= index + IDX_ONE;
            end else if (wrap_mode && !t_last) begin
              // The frame-ending beat does not count as a wrap.
              index <= '0;
              if (wraps != '1) begin
                wraps <= wraps + WRAP_ONE;
              end
            end
          end

          // Termination priority: t_last, then window full, then abort.
          if (beat && t_last) begin
            end_cause <= CAUSE_LAST;
            state     <= FLUSH;
          end else if (beat && index_last && !wrap_mode) begin
            end_cause <= CAUSE_FULL;
            state     <= FLUSH;
          end else if (abort) begin
            end_cause <= CAUSE_ABORT;
            state     <= FLUSH;
          end
        end

        FLUSH: begin
          // Finish only once the last write has left the output register.
          if (!m_valid || m_ready) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
